// File: rtl/tcdm2apb_pkg.sv
// Shared types and constants for the TCDM-to-APB bridge.
package tcdm2apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Read data returned when the APB slave never answers.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/xbar_tcdm_bus.sv
// TCDM request/response bus as exported by per_demux_wrap master ports.
interface XBAR_TCDM_BUS;

  logic        req;
  logic [31:0] add;
  logic        we_n;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  logic        r_opc;
  logic [31:0] r_rdata;

  modport Master (
    output req, add, we_n, wdata, be,
    input  gnt, r_valid, r_opc, r_rdata
  );

  modport Slave (
    input  req, add, we_n, wdata, be,
    output gnt, r_valid, r_opc, r_rdata
  );

endinterface

// File: rtl/tcdm2apb_bridge.sv
// Single-outstanding TCDM slave to APB master bridge with an ACCESS-phase
// timeout; the response is returned one cycle after the grant.
module tcdm2apb_bridge
  import tcdm2apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  XBAR_TCDM_BUS.Slave               slave,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [31:0]               pwdata,
  output logic [3:0]                pstrb,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [31:0]               prdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             done;
  logic             timeout;
  logic             r_valid_q;
  logic             r_opc_q;
  logic [31:0]      r_rdata_q;

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    psel    = 1'b0;
    penable = 1'b0;
    accept  = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (slave.req) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done    = 1'b1;
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the datapath registers are reset as well, so the APB outputs and
  // response fields read 0 (not X) until the first request is latched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      pwrite    <= 1'b0;
      cnt_q     <= '0;
      r_valid_q <= 1'b0;
      r_opc_q   <= 1'b0;
      r_rdata_q <= '0;
    end else begin
      if (accept) begin
        paddr  <= slave.add[APB_ADDR_WIDTH-1:0];
        pwdata <= slave.wdata;
        pstrb  <= slave.we_n ? 4'b0000 : slave.be;
        pwrite <= ~slave.we_n;
      end
      // Counts ACCESS cycles in which the slave is still stalling.
      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if (state_q == ACCESS && !pready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      r_valid_q <= done;
      if (done) begin
        r_opc_q   <= timeout | pslverr;
        r_rdata_q <= timeout ? TIMEOUT_RDATA : (pwrite ? 32'h0 : prdata);
      end
    end
  end

  assign slave.gnt     = done;
  assign slave.r_valid = r_valid_q;
  assign slave.r_opc   = r_opc_q;
  assign slave.r_rdata = r_rdata_q;

endmodule

// File: tb/tb_tcdm2apb_bridge.sv
// Self-checking bench for tcdm2apb_bridge: directed table, hand-written
// back-to-back and reset sequences, and randomized transfers against a model.
module tb_tcdm2apb_bridge;
  import tcdm2apb_pkg::*;

  localparam int T = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pwrite, psel, penable;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int n_checks = 0;
  int n_errors = 0;

  XBAR_TCDM_BUS bus ();

  tcdm2apb_bridge #(
    .APB_ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .slave   (bus.Slave),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .pwrite  (pwrite),
    .psel    (psel),
    .penable (penable),
    .pready  (pready),
    .pslverr (pslverr),
    .prdata  (prdata)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;      // ACCESS cycles with pready=0 before pready=1
    logic        err;
    logic [31:0] prd;
    int          exp_k;      // ACCESS cycle index (0-based) carrying gnt
    logic        exp_opc;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_pstrb;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: the slave stalls for v.waits cycles; the bridge gives up
  // after T stalled ACCESS cycles.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   to;
    r           = v;
    to          = (v.waits >= T);
    r.exp_k     = to ? T - 1 : v.waits;
    r.exp_opc   = to || v.err;
    r.exp_rdata = to ? TIMEOUT_RDATA : (v.we ? 32'h0 : v.prd);
    r.exp_pstrb = v.we ? v.be : 4'b0000;
    return r;
  endfunction

  task automatic run_xfer(input vec_t v, input bit drop_req);
    // Cycle 0: request presented in IDLE; stray pready must be ignored.
    @(posedge clk_i); #1;
    bus.req   = 1'b1;
    bus.add   = v.addr;
    bus.we_n  = ~v.we;
    bus.wdata = v.wdata;
    bus.be    = v.be;
    pready    = 1'($urandom_range(0, 1));
    pslverr   = 1'($urandom_range(0, 1));
    prdata    = $urandom;
    @(negedge clk_i);
    check("idle_gnt", bus.gnt, 0);
    check("idle_psel", psel, 0);
    // SETUP
    @(posedge clk_i); #1;
    if (drop_req) bus.req = 1'b0;
    pready = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_gnt", bus.gnt, 0);
    check("setup_paddr", paddr, v.addr);
    check("setup_pwdata", pwdata, v.wdata);
    check("setup_pstrb", pstrb, v.exp_pstrb);
    check("setup_pwrite", pwrite, v.we);
    // ACCESS
    for (int k = 0; k <= v.exp_k; k++) begin
      @(posedge clk_i); #1;
      pready  = (k >= v.waits);
      pslverr = v.err;
      prdata  = v.prd;
      @(negedge clk_i);
      check("access_psel", psel, 1);
      check("access_penable", penable, 1);
      check("access_paddr", paddr, v.addr);
      check("access_pstrb", pstrb, v.exp_pstrb);
      check("access_rvalid", bus.r_valid, 0);
      check("access_gnt", bus.gnt, (k == v.exp_k));
    end
    // Response cycle
    @(posedge clk_i); #1;
    bus.req = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = $urandom;
    @(negedge clk_i);
    check("resp_rvalid", bus.r_valid, 1);
    check("resp_ropc", bus.r_opc, v.exp_opc);
    check("resp_rdata", bus.r_rdata, v.exp_rdata);
    check("resp_psel", psel, 0);
    check("resp_gnt", bus.gnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [31:0] rd_a, rd_b;

    bus.req = 1'b0; bus.add = '0; bus.we_n = 1'b1; bus.wdata = '0; bus.be = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;

    // Reset state, checked before any clock edge.
    #2;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_gnt", bus.gnt, 0);
    check("rst_rvalid", bus.r_valid, 0);
    check("rst_ropc", bus.r_opc, 0);
    check("rst_rdata", bus.r_rdata, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", pstrb, 0);
    check("rst_pwrite", pwrite, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Directed table, fields in declaration order:
    // we, addr, wdata, be, waits, err, prdata, exp_k, exp_opc, exp_rdata, exp_pstrb
    vecs[0] = '{1'b0, 32'h1A10_0004, 32'h0000_0000, 4'hF, 0,  1'b0, 32'h1234_5678, 0, 1'b0, 32'h1234_5678, 4'h0};
    vecs[1] = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'h3, 3,  1'b0, 32'hFFFF_FFFF, 3, 1'b0, 32'h0000_0000, 4'h3};
    vecs[2] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'hF, 1,  1'b1, 32'h55AA_55AA, 1, 1'b1, 32'h55AA_55AA, 4'h0};
    vecs[3] = '{1'b0, 32'h0000_000C, 32'h0000_0000, 4'hF, 20, 1'b0, 32'h0000_0000, 3, 1'b1, 32'hDEAD_BEEF, 4'h0};
    vecs[4] = '{1'b1, 32'h0000_0010, 32'h0123_4567, 4'hC, 4,  1'b0, 32'h7777_7777, 3, 1'b1, 32'hDEAD_BEEF, 4'hC};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 4'hF, 0,  1'b1, 32'h1111_1111, 0, 1'b1, 32'h0000_0000, 4'hF};
    for (int i = 0; i < 6; i++) run_xfer(vecs[i], 1'b0);

    // Back-to-back reads with req held high: gnt at cycles 2 and 5.
    rd_a = 32'h0BAD_F00D;
    rd_b = 32'h600D_CAFE;
    @(posedge clk_i); #1;
    bus.req = 1'b1; bus.add = 32'h0000_0100; bus.we_n = 1'b1; bus.be = 4'hF; pready = 1'b0;
    @(negedge clk_i);
    check("b2b_c0_psel", psel, 0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("b2b_c1_setup", {psel, penable}, 2'b10);
    check("b2b_c1_paddr", paddr, 32'h0000_0100);
    @(posedge clk_i); #1;
    pready = 1'b1; prdata = rd_a; pslverr = 1'b0;
    @(negedge clk_i);
    check("b2b_c2_gnt", bus.gnt, 1);
    @(posedge clk_i); #1;
    bus.add = 32'h0000_0200; pready = 1'b0; prdata = $urandom;
    @(negedge clk_i);
    check("b2b_c3_rvalid", bus.r_valid, 1);
    check("b2b_c3_rdata", bus.r_rdata, rd_a);
    check("b2b_c3_psel", psel, 0);
    check("b2b_c3_gnt", bus.gnt, 0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("b2b_c4_setup", {psel, penable}, 2'b10);
    check("b2b_c4_paddr", paddr, 32'h0000_0200);
    check("b2b_c4_rvalid", bus.r_valid, 0);
    @(posedge clk_i); #1;
    pready = 1'b1; prdata = rd_b;
    @(negedge clk_i);
    check("b2b_c5_gnt", bus.gnt, 1);
    @(posedge clk_i); #1;
    bus.req = 1'b0; pready = 1'b0;
    @(negedge clk_i);
    check("b2b_c6_rvalid", bus.r_valid, 1);
    check("b2b_c6_rdata", bus.r_rdata, rd_b);

    // Reset pulsed in ACCESS: outputs drop at once, no response afterwards.
    @(posedge clk_i); #1;
    bus.req = 1'b1; bus.add = 32'h0000_0300; bus.we_n = 1'b0; bus.be = 4'h5; pready = 1'b0;
    @(posedge clk_i); #1;
    bus.req = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rstacc_before", {psel, penable}, 2'b11);
    #1 rst_ni = 1'b0;
    #1;
    check("rstacc_psel", psel, 0);
    check("rstacc_penable", penable, 0);
    check("rstacc_gnt", bus.gnt, 0);
    check("rstacc_pstrb", pstrb, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("rstacc_no_rvalid", bus.r_valid, 0);
      check("rstacc_idle_psel", psel, 0);
    end
    pready = 1'b0;

    // Randomized transfers against the model.
    for (int i = 0; i < 40; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.be    = 4'($urandom_range(0, 15));
      v.waits = $urandom_range(0, 6);
      v.err   = 1'($urandom_range(0, 3) == 0);
      v.prd   = $urandom;
      v = model(v);
      run_xfer(v, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
